// File: rtl/tl_pkg.sv
// TileLink-UL memory responder shared definitions:
// opcodes, FSM states and message sizing helpers.
package tl_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        IDLE,
        WBEAT,
        WACK,
        RWAIT,
        RBEAT
    } tl_state_e;

    // 8-byte beats; anything up to one beat is a single beat
    function automatic logic [4:0] tl_beats(input logic [2:0] size);
        return (size >= 3'd3) ? (5'd1 << (size - 3'd3)) : 5'd1;
    endfunction

endpackage

// File: rtl/tl_mem_sram.sv
// Single-port SRAM model: 1-cycle registered read,
// per-byte write enable. Contents are never reset.
module tl_mem_sram #(
    parameter int WORDS  = 1024,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [7:0]        be_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [WORDS];

    // Byte-masked write or registered read on each enabled cycle
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 8; b++) begin
                    if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_o <= mem[idx_i];
            end
        end
    end

endmodule

// File: rtl/tl_mem_responder.sv
// TileLink-UL manager endpoint: serves Get/Put from an
// on-chip SRAM, one message in flight at a time.
module tl_mem_responder #(
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MEM_WORDS = 1024,
    parameter int                READ_LAT  = 2,
    parameter int                SOURCE_W  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [2:0]          a_opcode_i,
    input  logic [2:0]          a_param_i,
    input  logic [2:0]          a_size_i,
    input  logic [SOURCE_W-1:0] a_source_i,
    input  logic [ADDR_W-1:0]   a_address_i,
    input  logic [7:0]          a_mask_i,
    input  logic [DATA_W-1:0]   a_data_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    output logic [2:0]          d_opcode_o,
    output logic [1:0]          d_param_o,
    output logic [2:0]          d_size_o,
    output logic [SOURCE_W-1:0] d_source_o,
    output logic [1:0]          d_sink_o,
    output logic                d_denied_o,
    output logic [DATA_W-1:0]   d_data_o,
    output logic                d_corrupt_o,
    output logic                d_valid_o,
    input  logic                d_ready_i
);

    import tl_pkg::*;

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] LIMIT =
        (ADDR_W+1)'(BASE_ADDR) + ((ADDR_W+1)'(MEM_WORDS) << 3);

    tl_state_e           state_q, state_d;
    logic [3:0]          lat_q, lat_d;
    logic [4:0]          beat_q, beat_d;
    logic [4:0]          beats_q, beats_d;
    logic [IDX_W-1:0]    base_q, base_d;
    logic [SOURCE_W-1:0] src_q, src_d;
    logic [2:0]          size_q, size_d;
    logic                den_q, den_d;
    logic                is_rd_q, is_rd_d;
    logic                dvalid_q, dvalid_d;
    logic [DATA_W-1:0]   ddata_q, ddata_d;
    logic                pend_q, pend_d;
    logic                rdy_q, rdy_d;

    logic                mem_en, mem_we;
    logic [7:0]          mem_be;
    logic [IDX_W-1:0]    mem_idx;
    logic [DATA_W-1:0]   mem_rdata;

    logic [ADDR_W-1:0]   off;
    logic [ADDR_W:0]     a_end;
    logic                a_den, a_put, a_fire;
    logic [IDX_W-1:0]    a_idx;
    logic                unused_bits;

    assign off    = a_address_i - BASE_ADDR;
    assign a_end  = {1'b0, a_address_i} + ((ADDR_W+1)'(1) << a_size_i);
    assign a_den  = (a_address_i < BASE_ADDR) || (a_end > LIMIT);
    assign a_idx  = off[IDX_W+2:3];
    assign a_put  = (a_opcode_i == TL_PUT_FULL) ||
                    (a_opcode_i == TL_PUT_PARTIAL);
    assign a_fire = a_valid_i && rdy_q;

    assign unused_bits = ^{a_param_i, off[ADDR_W-1:IDX_W+3], off[2:0]};

    assign a_ready_o   = rdy_q;
    assign d_opcode_o  = is_rd_q ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    assign d_param_o   = 2'd0;
    assign d_size_o    = size_q;
    assign d_source_o  = src_q;
    assign d_sink_o    = 2'd0;
    assign d_denied_o  = den_q;
    assign d_data_o    = ddata_q;
    assign d_corrupt_o = den_q && is_rd_q;
    assign d_valid_o   = dvalid_q;

    tl_mem_sram #(
        .WORDS  (MEM_WORDS),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .idx_i   (mem_idx),
        .wdata_i (a_data_i),
        .rdata_o (mem_rdata)
    );

    // Protocol state and the registered D-channel bundle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            beat_q   <= '0;
            beats_q  <= '0;
            base_q   <= '0;
            src_q    <= '0;
            size_q   <= '0;
            den_q    <= 1'b0;
            is_rd_q  <= 1'b0;
            dvalid_q <= 1'b0;
            ddata_q  <= '0;
            pend_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            beat_q   <= beat_d;
            beats_q  <= beats_d;
            base_q   <= base_d;
            src_q    <= src_d;
            size_q   <= size_d;
            den_q    <= den_d;
            is_rd_q  <= is_rd_d;
            dvalid_q <= dvalid_d;
            ddata_q  <= ddata_d;
            pend_q   <= pend_d;
            rdy_q    <= rdy_d;
        end
    end

    // Next state, SRAM control and D-channel updates
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        beat_d   = beat_q;
        beats_d  = beats_q;
        base_d   = base_q;
        src_d    = src_q;
        size_d   = size_q;
        den_d    = den_q;
        is_rd_d  = is_rd_q;
        dvalid_d = dvalid_q;
        ddata_d  = ddata_q;
        pend_d   = 1'b0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_be   = a_mask_i;
        mem_idx  = base_q + IDX_W'(beat_q);

        unique case (state_q)
            IDLE: begin
                if (a_fire) begin
                    src_d   = a_source_i;
                    size_d  = a_size_i;
                    base_d  = a_idx;
                    beats_d = tl_beats(a_size_i);
                    beat_d  = '0;
                    if (a_put) begin
                        is_rd_d = 1'b0;
                        den_d   = a_den;
                        mem_idx = a_idx;
                        mem_en  = !a_den;
                        mem_we  = 1'b1;
                        if (tl_beats(a_size_i) == 5'd1) begin
                            state_d  = WACK;
                            dvalid_d = 1'b1;
                        end else begin
                            state_d = WBEAT;
                            beat_d  = 5'd1;
                        end
                    end else begin
                        // unknown opcodes answer as a refused Get
                        is_rd_d = 1'b1;
                        den_d   = a_den || (a_opcode_i != TL_GET);
                        lat_d   = 4'(READ_LAT - 1);
                        state_d = RWAIT;
                    end
                end
            end
            WBEAT: begin
                if (a_fire) begin
                    mem_en = !den_q;
                    mem_we = 1'b1;
                    beat_d = beat_q + 5'd1;
                    if (beat_q == beats_q - 5'd1) begin
                        state_d  = WACK;
                        dvalid_d = 1'b1;
                    end
                end
            end
            WACK: begin
                if (d_ready_i) begin
                    dvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RWAIT: begin
                if (lat_q == 4'd0) begin
                    mem_en  = 1'b1;
                    pend_d  = 1'b1;
                    state_d = RBEAT;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            RBEAT: begin
                if (pend_q) begin
                    dvalid_d = 1'b1;
                    ddata_d  = den_q ? '0 : mem_rdata;
                end else if (dvalid_q && d_ready_i) begin
                    dvalid_d = 1'b0;
                    if (beat_q == beats_q - 5'd1) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 5'd1;
                        mem_en  = 1'b1;
                        mem_idx = base_q + IDX_W'(beat_q + 5'd1);
                        pend_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rdy_d = (state_d == IDLE) || (state_d == WBEAT);
    end

endmodule
